// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, controller state encoding and instruction-width helper
// for the accumulator CPU core.
package acc_cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // state     | meaning
    // S_FETCH   | read instruction beats at pc, MSB beat first
    // S_DECODE  | one idle bus cycle; branch/halt resolved here
    // S_EXEC_RD | operand read for ADD/AND/XOR/LDA
    // S_EXEC_WR | accumulator store for STO
    // S_HALTED  | bus idle until a resume pulse
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_RD,
        S_EXEC_WR,
        S_HALTED
    } state_t;

    function automatic int calc_nbeats(input int data_w, input int addr_w);
        return (3 + addr_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Accumulator update for the memory-operand instructions; any other opcode
// passes the accumulator through unchanged.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OP_ADD:  o_result = i_acc + i_rdata;
            OP_AND:  o_result = i_acc & i_rdata;
            OP_XOR:  o_result = i_acc ^ i_rdata;
            OP_LDA:  o_result = i_rdata;
            default: o_result = i_acc;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU: multi-beat instruction fetch over a req/ack
// memory bus, single-cycle decode, one data beat per memory-operand opcode.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resume,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              fetch,
    output logic              halt,
    output logic              zero
);

    localparam int NBEATS = calc_nbeats(DATA_W, ADDR_W);
    localparam int IR_W   = NBEATS * DATA_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    state_t              r_state;
    state_t              w_next;
    logic                r_run;
    logic [ADDR_W-1:0]   r_pc;
    logic [IR_W-1:0]     r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic [BEAT_W-1:0]   r_beat;

    logic [2:0]          w_op;
    logic [ADDR_W-1:0]   w_ir_addr;
    logic                w_done;
    logic                w_last;
    logic [DATA_W-1:0]   w_alu;

    assign w_op      = r_ir[ADDR_W+2:ADDR_W];
    assign w_ir_addr = r_ir[ADDR_W-1:0];
    assign w_done    = mem_req & mem_ack;
    assign w_last    = (r_beat == BEAT_W'(NBEATS - 1));

    // r_run keeps the bus quiet during the first cycle after reset release.
    assign mem_req   = r_run & ((r_state == S_FETCH) | (r_state == S_EXEC_RD) |
                                (r_state == S_EXEC_WR));
    assign mem_we    = r_run & (r_state == S_EXEC_WR);
    assign mem_addr  = (r_state == S_FETCH) ? r_pc : w_ir_addr;
    assign mem_wdata = r_acc;
    assign fetch     = (r_state == S_FETCH);
    assign halt      = (r_state == S_HALTED);
    assign zero      = (r_acc == '0);

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_op),
        .i_acc    (r_acc),
        .i_rdata  (mem_rdata),
        .o_result (w_alu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (w_done && w_last) w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_HLT:         w_next = S_HALTED;
                    OP_SKZ, OP_JMP: w_next = S_FETCH;
                    OP_STO:         w_next = S_EXEC_WR;
                    default:        w_next = S_EXEC_RD;
                endcase
            end
            S_EXEC_RD, S_EXEC_WR: if (w_done) w_next = S_FETCH;
            S_HALTED: if (resume) w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run  <= 1'b0;
            r_pc   <= ADDR_W'(RESET_PC);
            r_ir   <= '0;
            r_acc  <= '0;
            r_beat <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (w_done) begin
                        r_ir   <= IR_W'({r_ir, mem_rdata});
                        r_pc   <= r_pc + ADDR_W'(1);
                        r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_SKZ && r_acc == '0) r_pc <= r_pc + ADDR_W'(NBEATS);
                    else if (w_op == OP_JMP)           r_pc <= w_ir_addr;
                end
                S_EXEC_RD: if (w_done) r_acc <= w_alu;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core (8-bit data, 13-bit address): an instruction-level
// model predicts every bus beat; directed program plus random memory image.
module tb_acc_cpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        resume = 1'b0;
    logic        mem_req, mem_we, mem_ack, fetch, halt, zero;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(13), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .resume    (resume),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .fetch     (fetch),
        .halt      (halt),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:8191];
    int  wait_cnt = 0;
    bit  in_beat = 1'b0;
    bit  beat_done_ne = 1'b0;
    int  ack_mode = 0;   // 0 zero-wait, 1 random waits, 2 writes wait 3, 3 operand reads never ack
    int  load_sel = 0;
    int  cur_loaded = 0;

    assign mem_ack   = mem_req && (wait_cnt == 0);
    assign mem_rdata = mem[mem_addr];

    typedef struct { logic [12:0] addr; logic we; logic fe; logic [7:0] acc; } exp_t;
    typedef struct { logic [12:0] addr; logic we; logic [7:0] wdata; logic zero; } tr_t;
    exp_t q[$];
    tr_t  trace[$];

    int vectors = 0, miscompares = 0;
    int write_cnt = 0, wr_req_cycles = 0;
    logic [12:0] m_pc;
    logic [7:0]  m_acc;
    bit          m_halted;
    bit          hold_valid = 1'b0;
    logic [12:0] h_addr;
    logic        h_we;
    logic [7:0]  h_wdata;
    exp_t        e;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        case (ack_mode)
            0:       return 0;
            1:       return int'($urandom_range(0, 2));
            2:       return mem_we ? 3 : 0;
            default: return (!mem_we && !fetch) ? 1000000 : 0;
        endcase
    endfunction

    task automatic put(input int a, input logic [15:0] w);
        mem[a]     = w[15:8];
        mem[a + 1] = w[7:0];
    endtask

    task automatic load_mem(input int sel);
        for (int i = 0; i < 8192; i++) mem[i] = (sel == 2) ? 8'($urandom) : 8'h00;
        if (sel == 1) begin
            put(16'h0000, 16'hE020);  // JMP 0x0020
            put(16'h0020, 16'hA100);  // LDA 0x0100
            put(16'h0022, 16'h4101);  // ADD 0x0101
            put(16'h0024, 16'h2000);  // SKZ
            put(16'h0026, 16'h8102);  // XOR 0x0102
            put(16'h0028, 16'h2000);  // SKZ
            put(16'h002C, 16'hA103);  // LDA 0x0103
            put(16'h002E, 16'hC200);  // STO 0x0200
            put(16'h0030, 16'h0000);  // HLT
            put(16'h0032, 16'hFFFE);  // JMP 0x1FFE
            put(16'h1FFE, 16'hA104);  // LDA 0x0104
            mem[16'h100] = 8'h7F;
            mem[16'h101] = 8'h85;
            mem[16'h102] = 8'h04;
            mem[16'h103] = 8'h5A;
            mem[16'h104] = 8'h01;
        end
    endtask

    // Executes one whole instruction and queues the bus beats it must produce.
    task automatic model_step();
        logic [15:0] w;
        logic [12:0] a;
        logic [7:0]  d;
        w = {mem[m_pc], mem[13'(m_pc + 13'd1)]};
        a = w[12:0];
        q.push_back('{addr: m_pc, we: 1'b0, fe: 1'b1, acc: m_acc});
        q.push_back('{addr: 13'(m_pc + 13'd1), we: 1'b0, fe: 1'b1, acc: m_acc});
        m_pc = m_pc + 13'd2;
        case (w[15:13])
            3'd0: m_halted = 1'b1;
            3'd1: if (m_acc == 8'h00) m_pc = m_pc + 13'd2;
            3'd7: m_pc = a;
            3'd6: q.push_back('{addr: a, we: 1'b1, fe: 1'b0, acc: m_acc});
            default: begin
                d = mem[a];
                q.push_back('{addr: a, we: 1'b0, fe: 1'b0, acc: m_acc});
                case (w[15:13])
                    3'd2:    m_acc = m_acc + d;
                    3'd3:    m_acc = m_acc & d;
                    3'd4:    m_acc = m_acc ^ d;
                    default: m_acc = d;
                endcase
            end
        endcase
    endtask

    always @(posedge clk) begin
        #1;
        if (!mem_req) in_beat = 1'b0;
        else if (!in_beat || beat_done_ne) begin
            in_beat  = 1'b1;
            wait_cnt = pick();
        end else if (wait_cnt > 0) wait_cnt--;
    end

    always @(negedge clk) begin
        beat_done_ne = mem_req && mem_ack;
        if (reset) begin
            if (load_sel != cur_loaded) begin
                load_mem(load_sel);
                cur_loaded = load_sel;
            end
            m_pc = 13'd0; m_acc = 8'd0; m_halted = 1'b0;
            q.delete(); trace.delete();
            hold_valid = 1'b0; write_cnt = 0; wr_req_cycles = 0;
        end else begin
            if (halt) begin
                chk("halt_req", int'(mem_req), 0);
                chk("halt_model", int'(m_halted && q.size() == 0), 1);
                if (resume) m_halted = 1'b0;
            end
            if (hold_valid) begin
                chk("stall_req", int'(mem_req), 1);
                chk("stall_addr", int'(mem_addr), int'(h_addr));
                chk("stall_we", int'(mem_we), int'(h_we));
                chk("stall_wdata", int'(mem_wdata), int'(h_wdata));
            end
            hold_valid = 1'b0;
            if (mem_req && mem_we) wr_req_cycles++;
            if (mem_req && mem_ack) begin
                if (q.size() == 0 && !m_halted) model_step();
                if (q.size() == 0) chk("beat_while_halted", int'(m_halted), 0);
                else begin
                    e = q.pop_front();
                    chk("beat_addr", int'(mem_addr), int'(e.addr));
                    chk("beat_we", int'(mem_we), int'(e.we));
                    chk("beat_fetch", int'(fetch), int'(e.fe));
                    if (e.fe || e.we) chk("beat_wdata", int'(mem_wdata), int'(e.acc));
                    if (e.fe) chk("zero_flag", int'(zero), int'(e.acc == 8'h00));
                end
                if (trace.size() < 64)
                    trace.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata, zero: zero});
                if (mem_we) begin
                    write_cnt++;
                    mem[mem_addr] = mem_wdata;
                end
            end else if (mem_req) begin
                hold_valid = 1'b1;
                h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
            end
        end
    end

    initial begin
        load_sel = 1;
        ack_mode = 2;
        repeat (2) @(negedge clk);
        chk("rst_req", int'(mem_req), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_fetch", int'(fetch), 1);
        chk("rst_zero", int'(zero), 1);
        chk("rst_halt", int'(halt), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("c1_req", int'(mem_req), 1);
        chk("c1_addr", int'(mem_addr), 0);
        chk("c1_fetch_zero", int'(fetch && zero), 1);
        @(negedge clk);
        chk("c2_addr", int'(mem_addr), 1);
        chk("c2_fetch_zero", int'(fetch && zero), 1);
        resume = 1'b1;                // lands on a FETCH edge: must be ignored
        @(negedge clk);
        resume = 1'b0;

        for (int i = 0; i < 300 && !halt; i++) @(negedge clk);
        chk("halt_reached", int'(halt), 1);
        repeat (20) @(negedge clk);
        chk("halt_held", int'(halt && !mem_req), 1);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;

        for (int i = 0; i < 300 && trace.size() < 29; i++) @(negedge clk);
        chk("trace_len", int'(trace.size() >= 29), 1);
        if (trace.size() >= 29) begin
            chk("t1_addr", int'(trace[1].addr), 16'h0001);
            chk("t4_rd_addr", int'(trace[4].addr), 16'h0100);
            chk("add_acc", int'(trace[9].wdata), 8'h04);
            chk("add_zero", int'(trace[9].zero), 0);
            chk("skz_not_taken", int'(trace[10].addr), 16'h0026);
            chk("xor_acc", int'(trace[14].wdata), 8'h00);
            chk("xor_zero", int'(trace[14].zero), 1);
            chk("skz_taken", int'(trace[15].addr), 16'h002C);
            chk("sto_addr", int'(trace[20].addr), 16'h0200);
            chk("sto_we", int'(trace[20].we), 1);
            chk("sto_wdata", int'(trace[20].wdata), 8'h5A);
            chk("resume_addr", int'(trace[23].addr), 16'h0032);
            chk("jmp_addr0", int'(trace[25].addr), 16'h1FFE);
            chk("jmp_addr1", int'(trace[26].addr), 16'h1FFF);
            chk("pc_wrap", int'(trace[28].addr), 16'h0000);
        end
        chk("write_count", write_cnt, 1);
        chk("write_req_cycles", wr_req_cycles, 4);

        ack_mode = 3;
        for (int i = 0; i < 200 && !(mem_req && !fetch && !mem_we && !mem_ack); i++)
            @(negedge clk);
        chk("exec_rd_stalled", int'(mem_req && !fetch && !mem_we && !mem_ack), 1);
        chk("pre_reset_acc", int'(mem_wdata), 8'h01);
        #2 reset = 1'b1;
        #1;
        chk("abort_req", int'(mem_req), 0);
        chk("abort_acc", int'(mem_wdata), 0);
        chk("abort_zero_fetch", int'(zero && fetch), 1);
        chk("abort_pc", int'(mem_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_req", int'(mem_req), 1);
        chk("restart_addr", int'(mem_addr), 0);
        @(negedge clk);
        chk("restart_addr1", int'(mem_addr), 1);

        @(negedge clk);
        reset = 1'b1;
        load_sel = 2;
        ack_mode = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1 resume = ($urandom_range(0, 5) == 0);
        end
        resume = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised successor to the fixed 8-bit/13-bit accumulator RISC CPU. It keeps the same 8-opcode ISA. Data width and address width are parameters. Memory uses a req/ack handshake with arbitrary wait states, replacing the fixed clock-phase bus, and a halted core can be restarted. Each instruction word (3-bit opcode plus ADDR_W-bit operand address) is fetched MSB-first as NBEATS = ceil((3+ADDR_W)/DATA_W) consecutive memory words.

Parameters:
DATA_W, 8, accumulator and memory word width (>=4)
ADDR_W, 13, word address width; PC and operand address width (>=4)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
resume  in  1  one-cycle pulse; leaves HALTED
mem_req  out  1  bus request; held with addr/we/wdata stable until ack
mem_we  out  1  1=write (STO), 0=read
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  store data (= acc)
mem_rdata  in  DATA_W  read data, valid in a cycle where mem_req&mem_ack&!mem_we
mem_ack  in  1  completes the current beat in the cycle it is high with mem_req
fetch  out  1  high while in FETCH (instruction phase indicator)
halt  out  1  high in HALTED
zero  out  1  acc == 0

Behaviour:
- Reset (async): pc=RESET_PC, acc=0, ir=0, beat=0, state=FETCH. All outputs are 0 except fetch=1 and zero=1. mem_req rises on the first clock edge after reset deasserts.
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- A beat completes on an edge where mem_req&mem_ack. mem_req may stay high back-to-back. A zero-wait-state slave completes one beat per cycle.
- FETCH: mem_req=1, we=0, addr=pc.
  - Per completed beat: shift mem_rdata into ir (MSB beat first); pc=pc+1 mod 2^ADDR_W; beat++.
  - After beat NBEATS-1 completes, go to DECODE.
  - Unused top ir bits (NBEATS*DATA_W-3-ADDR_W) are ignored. Opcode = the 3 bits directly above the ADDR_W address field.
- DECODE (1 cycle, mem_req=0):
  - HLT -> HALTED.
  - SKZ: if zero then pc+=NBEATS (wraps). Then FETCH.
  - JMP: pc=ir_addr. Then FETCH.
  - ADD/AND/XOR/LDA -> EXEC_RD.
  - STO -> EXEC_WR.
- EXEC_RD: req, we=0, addr=ir_addr. On ack, acc is updated as follows, then go to FETCH:
  - ADD: (acc+rdata) mod 2^DATA_W, carry discarded.
  - AND: acc&rdata.
  - XOR: acc^rdata.
  - LDA: rdata.
- EXEC_WR: req, we=1, addr=ir_addr, wdata=acc. On ack -> FETCH. acc is unchanged.
- HALTED: mem_req=0, halt=1.
  - pc already points past the HLT instruction.
  - A resume pulse moves the core to FETCH on the next edge.
  - resume is ignored in every other state.
- Cycle counts with ack tied high: SKZ/JMP/HLT take NBEATS+1 cycles; ALU ops and STO take NBEATS+2 cycles.
- The zero output is combinational from acc and reflects the new acc the cycle after the update edge.
- Reset mid-transaction aborts it immediately: mem_req drops asynchronously and no acc or pc update occurs.
- A stalled ack (held low) holds the state, beat, addr, we and wdata indefinitely. There is no timeout.
- The pc wraps from 2^ADDR_W-1 to 0, including mid-instruction fetch.

Decomposition:
- Package acc_cpu_pkg holds:
  - opcode localparams (OP_HLT..OP_JMP);
  - state encoding (S_FETCH, S_DECODE, S_EXEC_RD, S_EXEC_WR, S_HALTED);
  - a function computing NBEATS from DATA_W and ADDR_W.
- Sub-module acc_cpu_alu (combinational, DATA_W parameter) computes the ADD/AND/XOR/LDA result.
- The controller, pc, ir and acc stay in acc_cpu_core.

Test Plan:
(All with DATA_W=8, ADDR_W=13, NBEATS=2, ack tied high unless stated.)
- Reset release:
  - cycle 1: req=1, addr=0x0000.
  - cycle 2: addr=0x0001.
  - fetch=1 and zero=1 throughout.
- LDA 0x0100 (mem[0x100]=0x7F), then ADD 0x0101 (=0x85): acc=0x04, carry discarded, zero=0.
  - Then XOR 0x0102 (=0x04): acc=0x00, zero=1.
- SKZ with acc=0 at pc 0x0004: next fetch addr=0x0008.
  - With acc=0x01, next fetch addr=0x0006.
  - JMP 0x1FFE: fetch addrs 0x1FFE, 0x1FFF; pc wraps to 0x0000.
- STO 0x0200 with acc=0x5A and ack delayed 3 cycles:
  - req/we=1, addr=0x0200, wdata=0x5A held stable for 4 cycles.
  - Exactly one write is accepted.
- HLT at 0x0010: halt=1, mem_req=0 indefinitely.
  - A resume pulse resumes fetch at 0x0012.
  - resume asserted during FETCH has no effect.
- Reset asserted mid-EXEC_RD with ack low: mem_req drops in the same cycle; acc=0, pc=0.
  - After release, fetch restarts at 0x0000.
